// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled deframer feeding a small FIFO drained by valid/ready.
// Framing and overrun errors are reported as single-cycle pulses.
module uart_rx #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] baud_div,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] rx_count,
    output logic       frame_err,
    output logic       overrun
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic         sync1_q, sync2_q, hist_q;
    logic         start_edge;
    state_t       state_q, state_d;
    logic [7:0]   div_q, div_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   half_m1, div_m1;
    logic         push, frame_err_d, frame_err_q;
    logic         do_pop, full, accept, overrun_d, overrun_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]   count_q, count_d;
    logic [7:0]   mem [DEPTH];

    assign start_edge = hist_q & ~sync2_q;
    assign half_m1    = (div_q >> 1) - 8'd1;
    assign div_m1     = div_q - 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        div_d       = div_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (en && start_edge) begin
                    state_d = START;
                    cnt_d   = 8'd0;
                    div_d   = (baud_div < 8'd2) ? 8'd2 : baud_div;
                end
            end
            START: begin
                if (cnt_q == half_m1) begin
                    cnt_d = 8'd0;
                    bit_d = 3'd0;
                    // A line already back high at mid start bit is a glitch, not a frame.
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == div_m1) begin
                    cnt_d   = 8'd0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == div_m1) begin
                    cnt_d       = 8'd0;
                    state_d     = IDLE;
                    push        = sync2_q;
                    frame_err_d = ~sync2_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d     = IDLE;
            push        = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    assign do_pop    = rx_valid & rx_ready;
    assign full      = (count_q == 3'(DEPTH));
    assign accept    = push & (~full | do_pop);
    assign overrun_d = push & full & ~do_pop;

    always_comb begin
        count_d = count_q;
        case ({accept, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 3'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            state_q     <= state_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Datapath registers are always re-initialised before use, so they carry no reset.
    always_ff @(posedge clk) begin
        div_q   <= div_d;
        cnt_q   <= cnt_d;
        shift_q <= shift_d;
        bit_q   <= bit_d;
        if (accept) mem[wr_ptr_q] <= shift_q;
    end

    assign rx_valid  = (count_q != 3'd0);
    assign rx_data   = rx_valid ? mem[rd_ptr_q] : 8'h00;
    assign rx_count  = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are driven on rxd, expected bytes queued,
// and compared as the FIFO is drained.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [7:0] baud_div = 8'd16;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .baud_div(baud_div), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
        @(posedge clk); #1 rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (d) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (d) @(posedge clk);
        #1 rxd = stop;
        repeat (d) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic pop_one(output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            d = rx_data;
            rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rxd = 1'b1; en = 1'b1; rx_ready = 1'b0; baud_div = 8'd16;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_valid, rx_count, frame_err, overrun} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_in: data=%02h valid=%b count=%0d fe=%b ov=%b, expected all 0",
                     rx_data, rx_valid, rx_count, frame_err, overrun);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rx_data, rx_valid, rx_count, frame_err, overrun} !== 13'd0 || fe_cnt != 0 || ov_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: data=%02h valid=%b count=%0d fe_pulses=%0d ov_pulses=%0d, expected all 0",
                     rx_data, rx_valid, rx_count, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_single_frame();
        int lat;
        logic [7:0] d;
        bit ok;
        baud_div = 8'd130;
        lat = 0;
        exp_q.push_back(8'hF0);
        fork
            send_frame(8'hF0, 1'b1, 130);
            begin
                @(negedge rxd);
                for (int i = 0; i < 3000; i++) begin
                    @(posedge clk); #1;
                    lat++;
                    if (rx_valid === 1'b1) break;
                end
            end
        join
        // 3 sync/edge cycles + half (65) + 9 bit periods (1170) to the stop-sample edge.
        n_checks++;
        if (lat != 3 + 65 + 1170) begin
            n_fail++;
            $display("FAIL single_latency: rx_valid after %0d clocks, expected %0d", lat, 3 + 65 + 1170);
        end
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_count: rx_count=%0d, expected 1", rx_count);
        end
        pop_one(d, ok);
        n_checks++;
        if (!ok || d !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_data: got %02h (valid=%0b), expected %02h", d, ok, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: rx_valid=%b after pop, expected 0", rx_valid);
        end
    endtask

    task automatic test_false_start_frame_err();
        int fe0;
        fe0 = fe_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL false_start: rx_count=%0d fe_pulses=%0d, expected 0 and 0", rx_count, fe_cnt - fe0);
        end
        baud_div = 8'd16;
        send_frame(8'h55, 1'b0, 16);
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (fe_cnt - fe0 != 1 || rx_count !== 3'd0) begin
            n_fail++;
            $display("FAIL frame_err: fe_pulse_cycles=%0d rx_count=%0d, expected 1 and 0", fe_cnt - fe0, rx_count);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        logic [7:0] d, e;
        bit ok;
        ov0 = ov_cnt;
        baud_div = 8'd16;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 16);
        end
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd4 || ov_cnt - ov0 != 1) begin
            n_fail++;
            $display("FAIL overrun_state: rx_count=%0d ov_pulse_cycles=%0d, expected 4 and 1", rx_count, ov_cnt - ov0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one(d, ok);
            n_checks++;
            if (!ok || d !== e) begin
                n_fail++;
                $display("FAIL overrun_drain: got %02h (valid=%0b), expected %02h", d, ok, e);
            end
        end
    endtask

    task automatic test_full_pop();
        int ov0;
        logic [7:0] d, e, popped;
        bit ok;
        baud_div = 8'd16;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 16);
        end
        ov0 = ov_cnt;
        popped = 8'h00;
        fork
            send_frame(8'h05, 1'b1, 16);
            begin
                @(negedge rxd);
                // Stop sample lands on clock 3 + 8 + 9*16 = 155 after the start fall.
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                popped = rx_data;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h05);
        e = exp_q.pop_front();
        n_checks++;
        if (popped !== e) begin
            n_fail++;
            $display("FAIL fullpop_head: popped %02h, expected %02h", popped, e);
        end
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd4 || ov_cnt != ov0) begin
            n_fail++;
            $display("FAIL fullpop_state: rx_count=%0d ov_pulse_cycles=%0d, expected 4 and 0", rx_count, ov_cnt - ov0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one(d, ok);
            n_checks++;
            if (!ok || d !== e) begin
                n_fail++;
                $display("FAIL fullpop_drain: got %02h (valid=%0b), expected %02h", d, ok, e);
            end
        end
    endtask

    task automatic test_min_div();
        logic [7:0] d;
        bit ok;
        baud_div = 8'd1;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 2);
        pop_one(d, ok);
        n_checks++;
        if (!ok || d !== exp_q[0]) begin
            n_fail++;
            $display("FAIL min_div: got %02h (valid=%0b), expected %02h", d, ok, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_enable_reset_abort();
        int fe0;
        baud_div = 8'd16;
        fe0 = fe_cnt;
        fork
            send_frame(8'h3C, 1'b1, 16);
            begin
                @(negedge rxd);
                // Data bit 3 is sampled at clock 75; drop the enable inside that bit.
                repeat (70) @(posedge clk);
                #1 en = 1'b0;
            end
        join
        @(posedge clk); #1 en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL en_abort: rx_count=%0d fe_pulse_cycles=%0d, expected 0 and 0", rx_count, fe_cnt - fe0);
        end
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 16);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 16);
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd2 || rx_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reenable_rx: rx_count=%0d head=%02h, expected 2 and %02h", rx_count, rx_data, exp_q[0]);
        end
        fork
            send_frame(8'h77, 1'b1, 16);
            begin
                @(negedge rxd);
                repeat (50) @(posedge clk);
                #1 rst = 1'b0;
                #1;
                n_checks++;
                if (rx_count !== 3'd0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rst_abort: rx_count=%0d valid=%b data=%02h, expected 0 0 00",
                             rx_count, rx_valid, rx_data);
                end
            end
        join
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_idle: rx_count=%0d valid=%b, expected 0 0", rx_count, rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_false_start_frame_err();
        test_overrun();
        test_full_pop();
        test_min_div();
        test_enable_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
